// File: rtl/icache_axi_rd_bridge_if.sv
// icache_axi_rd_bridge_if: i-cache miss port plus AXI4 AR/R channels seen by the read bridge
interface icache_axi_rd_bridge_if #(parameter int A_WIDTH = 32);
  logic req_strobe;
  logic [A_WIDTH-1:0] req_addr;
  logic [31:0] rsp_data;
  logic rsp_ready;
  logic rsp_err;
  logic [31:0] refill_cnt;
  logic [3:0] arid;
  logic [A_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport master (
    input req_strobe, req_addr, arready, rdata, rresp, rlast, rvalid,
    output rsp_data, rsp_ready, rsp_err, refill_cnt, arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
  modport slave (
    output req_strobe, req_addr, arready, rdata, rresp, rlast, rvalid,
    input rsp_data, rsp_ready, rsp_err, refill_cnt, arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: turns each i-cache miss strobe into one single-beat 32-bit AXI4 read
module icache_axi_rd_bridge #(
  parameter int A_WIDTH = 32,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input logic clk,
  input logic rst,
  icache_axi_rd_bridge_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR = 2'd1;
  localparam logic [1:0] R = 2'd2;
  localparam logic [1:0] RSP = 2'd3;
  logic [1:0] state;
  logic unused;
  assign unused = &{1'b0, bus.rlast, bus.req_addr[1:0]};
  assign bus.arid = AXI_ID;
  assign bus.arlen = 8'd0;
  assign bus.arsize = 3'b010;
  assign bus.arburst = 2'b01;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.arvalid <= 1'b0;
      bus.rready <= 1'b0;
      bus.rsp_ready <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_data <= '0;
      bus.araddr <= '0;
      bus.refill_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_strobe) begin
          bus.araddr <= {bus.req_addr[A_WIDTH-1:2], 2'b00};
          bus.arvalid <= 1'b1;
          state <= AR;
        end
        AR: if (bus.arready) begin
          bus.arvalid <= 1'b0;
          bus.rready <= 1'b1;
          state <= R;
        end
        R: if (bus.rvalid) begin
          bus.rsp_data <= bus.rdata;
          bus.rsp_ready <= 1'b1;
          bus.rsp_err <= bus.rresp != 2'b00;
          bus.rready <= 1'b0;
          bus.refill_cnt <= bus.refill_cnt + 32'd1;
          state <= RSP;
        end
        default: begin
          bus.rsp_ready <= 1'b0;
          bus.rsp_err <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb_icache_axi_rd_bridge: scoreboard bench for the i-cache AXI read bridge
module tb_icache_axi_rd_bridge;
  typedef struct packed {
    logic [31:0] d;
    logic e;
    logic [31:0] c;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  int ar_hs = 0;
  logic [31:0] exp_cnt = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];
  icache_axi_rd_bridge_if #(.A_WIDTH(32)) bus ();
  icache_axi_rd_bridge #(.A_WIDTH(32), .AXI_ID(4'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.rsp_ready === 1'b1) begin
    pulses++;
    obs_q.push_back('{d: bus.rsp_data, e: bus.rsp_err, c: bus.refill_cnt});
  end
  always @(posedge clk) if (!rst && bus.arvalid === 1'b1 && bus.arready === 1'b1) ar_hs++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_cnt++;
    exp_q.push_back('{d: d, e: e, c: exp_cnt});
  endtask
  task automatic txn(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] resp,
                     input int ar_wait, input int r_wait, input bit flush,
                     output logic [31:0] lat, output bit stable);
    bus.req_strobe = 1'b1;
    bus.req_addr = addr;
    tick();
    bus.req_strobe = 1'b0;
    lat = bus.araddr;
    stable = bus.arvalid === 1'b1;
    repeat (ar_wait) begin
      tick();
      stable = stable && bus.arvalid === 1'b1 && bus.araddr === lat && bus.rready === 1'b0;
    end
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    if (flush) bus.req_addr = 32'h8000_0000;
    repeat (r_wait) begin
      stable = stable && bus.rready === 1'b1 && bus.arvalid === 1'b0;
      tick();
    end
    stable = stable && bus.rready === 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata = d;
    bus.rresp = resp;
    push_exp(d, resp != 2'b00);
    tick();
    bus.rvalid = 1'b0;
    bus.rresp = 2'b00;
    repeat (3) tick();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_chk++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
    n_chk++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b want 0", bus.rready); end
    n_chk++; if (bus.rsp_ready !== 1'b0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got ready=%b err=%b want 0 0", bus.rsp_ready, bus.rsp_err); end
    n_chk++; if (bus.rsp_data !== 32'd0 || bus.araddr !== 32'd0) begin n_fail++; $display("FAIL reset_data_addr: got data=%h addr=%h want 0 0", bus.rsp_data, bus.araddr); end
    n_chk++; if (bus.refill_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.refill_cnt); end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
  endtask
  task automatic test_ideal();
    rsp_t e, o;
    bus.arready = 1'b1;
    bus.req_strobe = 1'b1;
    bus.req_addr = 32'hBFC0_0004;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        bus.req_strobe = 1'b0;
        n_chk++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL ideal_ar: got arvalid=%b araddr=%h want 1 bfc00004", bus.arvalid, bus.araddr); end
      end
      n_chk++; if (bus.rsp_ready !== (c == 3)) begin n_fail++; $display("FAIL ideal_rsp_cycle%0d: got %b want %b", c, bus.rsp_ready, c == 3); end
      bus.rvalid = bus.rready;
      bus.rdata = 32'h1234_5678;
      if (bus.rready === 1'b1) push_exp(32'h1234_5678, 1'b0);
    end
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    n_chk++; if (bus.refill_cnt !== 32'd1) begin n_fail++; $display("FAIL ideal_cnt: got %0d want 1", bus.refill_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL ideal_sb: got no response want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL ideal_sb: got %h want %h", o, e); end end
    end
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ideal_extra: got %0d extra responses want 0", obs_q.size()); obs_q.delete(); end
  endtask
  task automatic test_backpressure();
    rsp_t e, o;
    logic [31:0] lat;
    bit st;
    int p0 = pulses;
    txn(32'h0000_4440, 32'hA5A5_0001, 2'b00, 5, 7, 1'b0, lat, st);
    n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", st); end
    n_chk++; if (lat !== 32'h0000_4440) begin n_fail++; $display("FAIL bp_addr: got %h want 00004440", lat); end
    n_chk++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL bp_pulses: got %0d want 1", pulses - p0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL bp_sb: got no response want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL bp_sb: got %h want %h", o, e); end end
    end
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra responses want 0", obs_q.size()); obs_q.delete(); end
  endtask
  task automatic test_unaligned();
    rsp_t e, o;
    logic [31:0] lat;
    bit st;
    txn(32'h0000_1007, 32'hCAFE_F00D, 2'b00, 1, 1, 1'b0, lat, st);
    n_chk++; if (lat !== 32'h0000_1004) begin n_fail++; $display("FAIL unal_addr: got %h want 00001004", lat); end
    n_chk++; if (bus.arlen !== 8'd0 || bus.arsize !== 3'd2 || bus.arburst !== 2'd1 || bus.arid !== 4'd0) begin
      n_fail++; $display("FAIL unal_const: got len=%0d size=%0d burst=%0d id=%0d want 0 2 1 0", bus.arlen, bus.arsize, bus.arburst, bus.arid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL unal_sb: got no response want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL unal_sb: got %h want %h", o, e); end end
    end
  endtask
  task automatic test_flush();
    rsp_t e, o;
    logic [31:0] lat;
    bit st;
    int h0 = ar_hs;
    int p0 = pulses;
    txn(32'h0000_2000, 32'h0BAD_C0DE, 2'b00, 0, 3, 1'b1, lat, st);
    n_chk++; if (lat !== 32'h0000_2000) begin n_fail++; $display("FAIL flush_addr: got %h want 00002000", lat); end
    n_chk++; if (ar_hs - h0 != 1 || bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL flush_ar: got %0d handshakes arvalid=%b want 1 0", ar_hs - h0, bus.arvalid); end
    n_chk++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL flush_pulses: got %0d want 1", pulses - p0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL flush_sb: got no response want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL flush_sb: got %h want %h", o, e); end end
    end
  endtask
  task automatic test_error();
    rsp_t e, o;
    logic [31:0] lat;
    bit st;
    txn(32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0, lat, st);
    n_chk++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_after: got %b want 0", bus.rsp_err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL err_sb: got no response want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL err_sb: got %h want %h", o, e); end end
    end
  endtask
  task automatic test_back_to_back();
    rsp_t e, o;
    bus.req_strobe = 1'b1;
    bus.req_addr = 32'h0000_5000;
    tick();
    bus.req_strobe = 1'b0;
    n_chk++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got arvalid=%b want 1", bus.arvalid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    n_chk++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || bus.refill_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid: got arvalid=%b rready=%b cnt=%0d want 0 0 0", bus.arvalid, bus.rready, bus.refill_cnt);
    end
    bus.arready = 1'b1;
    bus.req_strobe = 1'b1;
    bus.req_addr = 32'h0000_6000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 8) bus.req_strobe = 1'b0;
      n_chk++; if (bus.arvalid !== (c == 1 || c == 5)) begin n_fail++; $display("FAIL b2b_ar_cycle%0d: got %b want %b", c, bus.arvalid, c == 1 || c == 5); end
      n_chk++; if (bus.rsp_ready !== (c == 3 || c == 7)) begin n_fail++; $display("FAIL b2b_rsp_cycle%0d: got %b want %b", c, bus.rsp_ready, c == 3 || c == 7); end
      bus.rvalid = bus.rready;
      bus.rdata = 32'h0000_1000 + 32'(c);
      if (bus.rready === 1'b1) push_exp(32'h0000_1000 + 32'(c), 1'b0);
    end
    bus.arready = 1'b0;
    bus.rvalid = 1'b0;
    repeat (3) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb: got no response want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", o, e); end end
    end
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra responses want 0", obs_q.size()); obs_q.delete(); end
  endtask
  initial begin
    bus.req_strobe = 1'b0;
    bus.req_addr = '0;
    bus.arready = 1'b0;
    bus.rdata = '0;
    bus.rresp = 2'b00;
    bus.rlast = 1'b1;
    bus.rvalid = 1'b0;
    test_reset();
    test_ideal();
    test_backpressure();
    test_unaligned();
    test_flush();
    test_error();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
